muldiv_unit: RTL and testbench

- Iterative RV32M-style multiply/divide unit; sits beside the single-cycle ALU in the execute stage.
- Handles all eight M-extension operations on XLEN-bit operands through a valid/ready handshake.
- Uses one radix-2 step per clock for the general case and completes special cases early.
- The pipeline stalls on ready_o low and kills in-flight work with kill_i.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
// Optional MULDIV_FAST_MUL_EN (see muldiv_unit) does not change anything in this package.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_op1(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_op2(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} accumulator: shift-add for multiply,
// restoring shift-subtract for divide (remainder in hi, quotient bits enter lo).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                is_div_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     operand_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem;
    logic [XLEN:0] diff;

    // The partial remainder is always below 2*divisor, so diff[XLEN] is a clean borrow flag.
    always_comb begin
        sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        rem  = acc_i[2*XLEN-1:XLEN-1];
        diff = rem - {1'b0, operand_i};
        if (is_div_i) begin
            if (diff[XLEN]) begin
                acc_o = {rem[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end else begin
                acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and kill.
// Define MULDIV_FAST_MUL_EN to compute the four multiply ops combinationally on accept.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand1_i,
    input  logic [XLEN-1:0] operand2_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    muldiv_op_e         op_q, op_d;
    logic               neg_q, neg_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]    opnd_q, opnd_d;
    logic [XLEN-1:0]    result_q, result_d;

    muldiv_op_e         op_in;
    logic               sign1, sign2, accept, special;
    logic [XLEN-1:0]    mag1, mag2, special_res, final_res, div_val;
    logic [2*XLEN-1:0]  step_acc, prod;

    assign op_in  = muldiv_op_e'(op_i);
    assign sign1  = is_signed_op1(op_in) & operand1_i[XLEN-1];
    assign sign2  = is_signed_op2(op_in) & operand2_i[XLEN-1];
    assign mag1   = sign1 ? -operand1_i : operand1_i;
    assign mag2   = sign2 ? -operand2_i : operand2_i;
    assign accept = (state_q == IDLE) && valid_i && !kill_i;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{sign1}}, operand1_i} * {{XLEN{sign2}}, operand2_i};
`endif

    // Requests that finish without iterating: divide by zero, signed overflow, trivial multiply.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (is_div(op_in)) begin
            if (operand2_i == '0) begin
                special     = 1'b1;
                special_res = is_rem(op_in) ? operand1_i : '1;
            end else if (is_signed_op1(op_in) && operand1_i == MIN_INT && operand2_i == '1) begin
                special     = 1'b1;
                special_res = is_rem(op_in) ? '0 : MIN_INT;
            end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            special     = 1'b1;
            special_res = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
            special     = (operand1_i == '0) || (operand2_i == '0);
`endif
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i  (is_div(op_q)),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc)
    );

    // Sign fixup applies to the full product, but only to the selected quotient/remainder.
    always_comb begin
        prod    = neg_q ? -step_acc : step_acc;
        div_val = is_rem(op_q) ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
        if (is_div(op_q)) begin
            final_res = neg_q ? -div_val : div_val;
        end else begin
            final_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : BUSY;
            BUSY: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: if (ready_i || kill_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o  = (state_q == IDLE);
        valid_o  = (state_q == DONE);
        busy_o   = (state_q != IDLE);
        result_o = result_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        if (accept) begin
            op_d   = op_in;
            neg_d  = (is_div(op_in) && op_in[1]) ? sign1 : (sign1 ^ sign2);
            acc_d  = {{XLEN{1'b0}}, mag1};
            opnd_d = mag2;
            if (special) begin
                cnt_d    = '0;
                result_d = special_res;
            end else begin
                cnt_d = CNT_W'(XLEN);
            end
        end else if (state_q == BUSY) begin
            if (kill_i) begin
                cnt_d = '0;
            end else begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) result_d = final_res;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a monitor pops on valid_o.
// Honours MULDIV_FAST_MUL_EN when computing the expected multiply latency.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int PERIOD = 10;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [31:0] operand1_i;
    logic [31:0] operand2_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] res;
        int          lat;
        longint      acc;
        string       name;
    } exp_t;

    exp_t        expQ[$];
    int          nCompared = 0;
    int          nMismatch = 0;
    logic [31:0] heldRes = '0;
    logic        prevValid = 1'b0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .operand1_i (operand1_i),
        .operand2_i (operand2_i),
        .kill_i     (kill_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .busy_o     (busy_o)
    );

    always #(PERIOD/2) clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: plain 64-bit arithmetic following the RV32M rules.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ub, p;
        longint unsigned ua64, ub64, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = ua64 * ub64; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Clock edges from the accepting edge to the edge that raises valid_o.
    function automatic int expLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 0) return 0;
            if ((op == 3'd4 || op == 3'd6) && a == MIN_INT && b == 32'hFFFF_FFFF) return 0;
            return XLEN;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 0;
`else
        return (a == 0 || b == 0) ? 0 : XLEN;
`endif
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MIN_INT;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        exp_t e;
        bit   accepted = 1'b0;
        @(negedge clk_i);
        valid_i = 1'b1;
        op_i = op;
        operand1_i = a;
        operand2_i = b;
        for (int i = 0; i < 200; i++) begin
            if (ready_o) begin
                @(posedge clk_i);
                accepted = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!accepted) begin
            nCompared++;
            nMismatch++;
            $display("[TB] FAIL accept_timeout %s: ready_o stayed 0, required 1", name);
        end else begin
            e.res = refModel(op, a, b);
            e.lat = expLatency(op, a, b);
            e.acc = longint'($time);
            e.name = name;
            expQ.push_back(e);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        op_i = 3'($urandom);
        operand1_i = $urandom;
        operand2_i = $urandom;
    endtask

    task automatic waitDone(input bit randReady);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (randReady) ready_i = 1'($urandom_range(0, 1));
            if (ready_o) return;
        end
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL done_timeout: ready_o stayed 0, required 1");
    endtask

    // Monitor: pops on each new result, then checks the result holds while valid_o stays high.
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (!rst_ni) begin
            prevValid = 1'b0;
        end else begin
            if (valid_o && !prevValid) begin
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("[TB] FAIL unexpected_valid: got result 0x%08h, required no result", result_o);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, "_result"}, result_o, e.res);
                    checkOutput({e.name, "_latency"}, 32'(int'((longint'($time) - 1 - e.acc) / PERIOD)), 32'(e.lat));
                    heldRes = e.res;
                end
            end else if (valid_o) begin
                checkOutput("result_hold", result_o, heldRes);
            end
            prevValid = valid_o;
        end
    end

    initial begin
        #(PERIOD * 90000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int validSeen;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        rst_ni = 1'b0;
        valid_i = 1'b0;
        kill_i = 1'b0;
        ready_i = 1'b1;
        op_i = 3'd0;
        operand1_i = '0;
        operand2_i = '0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_ready", {31'b0, ready_o}, 32'd1);
        checkOutput("reset_valid", {31'b0, valid_o}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("reset_result", result_o, 32'd0);
        rst_ni = 1'b1;

        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
        checkOutput("mul_ready_low", {31'b0, ready_o}, 32'd0);
        checkOutput("mul_busy_high", {31'b0, busy_o}, 32'd1);
        waitDone(1'b0);
        applyStimulus(3'd1, MIN_INT, MIN_INT, "mulh_min");          waitDone(1'b0);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu"); waitDone(1'b0);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");  waitDone(1'b0);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, "div_-7_2");      waitDone(1'b0);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_-7_2");      waitDone(1'b0);
        applyStimulus(3'd5, 32'd100, 32'd7, "divu_100_7");          waitDone(1'b0);
        applyStimulus(3'd7, 32'd100, 32'd7, "remu_100_7");          waitDone(1'b0);
        applyStimulus(3'd4, 32'd5, 32'd0, "div_by_zero");           waitDone(1'b0);
        applyStimulus(3'd6, 32'd5, 32'd0, "rem_by_zero");           waitDone(1'b0);
        applyStimulus(3'd4, MIN_INT, 32'hFFFF_FFFF, "div_ovf");     waitDone(1'b0);
        applyStimulus(3'd6, MIN_INT, 32'hFFFF_FFFF, "rem_ovf");     waitDone(1'b0);

        // Backpressure: hold the result for five cycles, then consume it.
        ready_i = 1'b0;
        applyStimulus(3'd5, 32'd100, 32'd7, "divu_backpressure");
        for (int i = 0; i < 100 && !valid_o; i++) @(negedge clk_i);
        repeat (5) begin
            @(negedge clk_i);
            checkOutput("bp_valid_held", {31'b0, valid_o}, 32'd1);
            checkOutput("bp_ready_low", {31'b0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("bp_valid_cleared", {31'b0, valid_o}, 32'd0);
        checkOutput("bp_ready_back", {31'b0, ready_o}, 32'd1);

        // Kill coinciding with the result handshake still consumes it.
        ready_i = 1'b0;
        applyStimulus(3'd6, 32'd5, 32'd0, "rem_kill_handshake");
        kill_i = 1'b1;
        ready_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        checkOutput("killhs_ready", {31'b0, ready_o}, 32'd1);
        checkOutput("killhs_valid", {31'b0, valid_o}, 32'd0);

        // Kill at step 10 of a general divide: no result may ever appear.
        applyStimulus(3'd4, 32'd1000, 32'd3, "div_killed");
        repeat (9) @(negedge clk_i);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        if (expQ.size() > 0) void'(expQ.pop_back());
        checkOutput("kill_ready", {31'b0, ready_o}, 32'd1);
        checkOutput("kill_busy", {31'b0, busy_o}, 32'd0);
        validSeen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) validSeen++;
        end
        checkOutput("kill_no_valid", 32'(validSeen), 32'd0);

        // Kill in IDLE blocks an accept.
        @(negedge clk_i);
        valid_i = 1'b1;
        kill_i = 1'b1;
        op_i = 3'd0;
        operand1_i = 32'd3;
        operand2_i = 32'd5;
        @(negedge clk_i);
        checkOutput("idle_kill_ready", {31'b0, ready_o}, 32'd1);
        checkOutput("idle_kill_busy", {31'b0, busy_o}, 32'd0);
        valid_i = 1'b0;
        kill_i = 1'b0;

        // Reset in the middle of a multiply.
        applyStimulus(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, "mulhu_reset");
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_ready", {31'b0, ready_o}, 32'd1);
        checkOutput("midrst_valid", {31'b0, valid_o}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("midrst_result", result_o, 32'd0);
        expQ.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(3'd0, 32'd3, 32'd4, "mul_after_reset");
        waitDone(1'b0);

        // Randomized operations with random consumer backpressure.
        repeat (80) begin
            rop = 3'($urandom_range(0, 7));
            ra = pickOperand();
            rb = pickOperand();
            applyStimulus(rop, ra, rb, "random");
            waitDone(1'b1);
        end
        ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
